// File: rtl/spram_fifo_pkg.sv
// Shared types and sizing helpers for the paced single-port-RAM FIFO.
package spram_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA
    } state_e;

    localparam int DEF_ADDR_BITS = 14;

    function automatic int depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    localparam int DEPTH = depth(DEF_ADDR_BITS);

endpackage

// File: rtl/spram_sp.sv
// Single-port RAM with registered read; behavioural model of SB_SPRAM256KA.
module spram_sp #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 we,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem_q [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/spram_fifo_paced.sv
// Byte FIFO over one single-port RAM; writes own the port, reads are
// released to the consumer, optionally one per pacing tick.
module spram_fifo_paced
    import spram_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_BITS  = 14,
    parameter int PACE_BITS  = 19,
    parameter int HIGH_WATER = 12288
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   write_data,
    input  logic               write_strobe,
    output logic               full,
    output logic               overflow,
    input  logic               clear_overflow,
    input  logic               read_ready,
    input  logic               pace_enable,
    output logic [WIDTH-1:0]   read_data,
    output logic               read_valid,
    output logic [ADDR_BITS:0] count,
    output logic               high_water
);

    localparam logic [ADDR_BITS:0] CNT_FULL = (ADDR_BITS+1)'(depth(ADDR_BITS));
    localparam logic [ADDR_BITS:0] CNT_HW   = (ADDR_BITS+1)'(HIGH_WATER);

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]     count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [PACE_BITS-1:0]   pace_q, pace_d;
    logic                   pend_q, pend_d;

    logic                   push;
    logic                   drop;
    logic                   issue;
    logic                   can_read;
    logic [ADDR_BITS-1:0]   ram_addr;
    logic [WIDTH-1:0]       ram_rdata;

    assign full       = (count_q == CNT_FULL);
    assign high_water = (count_q >= CNT_HW);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign read_valid = (state_q == DATA);
    assign read_data  = read_valid ? ram_rdata : '0;

    assign push     = write_strobe & ~full;
    assign drop     = write_strobe & full;
    assign can_read = (count_q != '0) & read_ready
                    & (pend_q | ~pace_enable);

    // A pending read in ISSUE yields the port to any write strobe.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (can_read) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!write_strobe) begin
                    issue   = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pace_d     = pace_q + 1'b1;
        pend_d     = pend_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end else if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end

        // A tick landing on an issue cycle is kept for the next read.
        if (pace_q == '0) begin
            pend_d = 1'b1;
        end else if (issue) begin
            pend_d = 1'b0;
        end
    end

    assign ram_addr = push ? wr_ptr_q : rd_ptr_q;

    spram_sp #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .wdata (write_data),
        .we    (push),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            pace_q     <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            pace_q     <= pace_d;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: tb/tb_spram_fifo_paced.sv
// Self-checking bench for spram_fifo_paced: directed tables, corner
// sequences and a randomized run against a queue-based reference.
module tb_spram_fifo_paced;

    localparam int W     = 8;
    localparam int AB    = 4;
    localparam int PB    = 4;
    localparam int HW    = 12;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  write_data;
    logic          write_strobe;
    logic          full;
    logic          overflow;
    logic          clear_overflow;
    logic          read_ready;
    logic          pace_enable;
    logic [W-1:0]  read_data;
    logic          read_valid;
    logic [AB:0]   count;
    logic          high_water;

    always #5 clk = ~clk;

    spram_fifo_paced #(
        .WIDTH      (W),
        .ADDR_BITS  (AB),
        .PACE_BITS  (PB),
        .HIGH_WATER (HW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .full           (full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .read_ready     (read_ready),
        .pace_enable    (pace_enable),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .count          (count),
        .high_water     (high_water)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    logic [7:0] mq[$];
    logic       ovf_m;
    int         last_pulse;

    typedef struct {
        logic       ws;
        logic [7:0] wd;
        logic       vld;
        logic [7:0] rd;
        logic [4:0] cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        write_strobe   = 1'b0;
        write_data     = '0;
        clear_overflow = 1'b0;
        reset          = 1'b1;
        step();
        step();
        reset          = 1'b0;
        mq.delete();
        ovf_m          = 1'b0;
        last_pulse     = -100;
    endtask

    task automatic push1(input logic [7:0] d);
        write_strobe = 1'b1;
        write_data   = d;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int bound,
                              output logic [7:0] d, output int at);
        d  = '0;
        at = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (read_valid) begin
                d  = read_data;
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s: no read_valid within %0d cycles", nm, bound);
    endtask

    // One cycle of randomized/drain traffic checked against the queue model.
    task automatic mstep(input logic ws, input logic [7:0] wd,
                         input logic clr);
        if (ws && mq.size() == DEPTH) begin
            ovf_m = 1'b1;
        end else begin
            if (ws) mq.push_back(wd);
            if (clr) ovf_m = 1'b0;
        end
        write_strobe   = ws;
        write_data     = wd;
        clear_overflow = clr;
        step();
        if (read_valid) begin
            if (mq.size() == 0) begin
                chk("rnd_pop_empty", 32'd1, 32'd0);
            end else begin
                chk("rnd_data", read_data, mq.pop_front());
            end
            chk("rnd_gap", (cyc - last_pulse) >= 3, 1);
            last_pulse = cyc;
        end
        chk("rnd_count", count, mq.size());
        chk("rnd_full", full, mq.size() == DEPTH);
        chk("rnd_hw", high_water, mq.size() >= HW);
        chk("rnd_ovf", overflow, ovf_m);
    endtask

    initial begin
        logic [7:0] d;
        int         at1, at2, at3;
        int         pulses;
        int         wprob;

        tbl[0]  = '{1'b1, 8'h41, 1'b0, 8'h00, 5'd1};
        tbl[1]  = '{1'b1, 8'h42, 1'b0, 8'h00, 5'd2};
        tbl[2]  = '{1'b1, 8'h43, 1'b0, 8'h00, 5'd3};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 8'h41, 5'd2};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd2};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd2};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h42, 5'd1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h43, 5'd0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd0};

        // reset state
        pace_enable = 1'b0;
        read_ready  = 1'b1;
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_valid", read_valid, 0);
        chk("rst_rdata", read_data, 0);
        chk("rst_hw", high_water, 0);

        // 1: basic echo, cycle-exact table
        for (int i = 0; i < 12; i++) begin
            write_strobe = tbl[i].ws;
            write_data   = tbl[i].wd;
            step();
            chk($sformatf("echo_valid[%0d]", i), read_valid, tbl[i].vld);
            chk($sformatf("echo_data[%0d]", i), read_data, tbl[i].rd);
            chk($sformatf("echo_count[%0d]", i), count, tbl[i].cnt);
        end
        chk("echo_ovf", overflow, 0);

        // 2: write priority over a pending read
        do_reset();
        for (int k = 0; k < 7; k++) begin
            write_strobe = 1'b1;
            write_data   = 8'hA0 + 8'(k);
            step();
            chk($sformatf("prio_novalid[%0d]", k), read_valid, 0);
        end
        write_strobe = 1'b0;
        step();
        chk("prio_valid", read_valid, 1);
        chk("prio_data", read_data, 8'hA0);
        chk("prio_count", count, 6);
        for (int k = 1; k < 7; k++) begin
            wait_valid("prio_drain", 10, d, at1);
            chk($sformatf("prio_drain[%0d]", k), d, 8'hA0 + 8'(k));
        end
        step();
        chk("prio_empty", count, 0);

        // 3: full, drop, sticky overflow, drain and wrap
        read_ready = 1'b0;
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            push1(8'(i));
            if (i == 14) chk("full_early", full, 0);
            if (i == 15) begin
                chk("full_set", full, 1);
                chk("full_cnt", count, 16);
                chk("full_ovf0", overflow, 0);
            end
            if (i == 16) begin
                chk("drop_ovf", overflow, 1);
                chk("drop_cnt", count, 16);
            end
        end
        step();
        chk("ovf_sticky", overflow, 1);
        write_strobe   = 1'b1;
        write_data     = 8'h55;
        clear_overflow = 1'b1;
        step();
        chk("ovf_setwins", overflow, 1);
        chk("ovf_setwins_cnt", count, 16);
        write_strobe = 1'b0;
        step();
        clear_overflow = 1'b0;
        chk("ovf_clear", overflow, 0);
        read_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_valid("full_drain", 10, d, at1);
            chk($sformatf("full_drain[%0d]", i), d, 8'(i));
        end
        step();
        chk("full_drained", count, 0);
        for (int r = 0; r < 2; r++) begin
            read_ready = 1'b0;
            for (int i = 0; i < 10; i++) push1(8'h20 + 8'(r * 16 + i));
            chk($sformatf("wrap_cnt[%0d]", r), count, 10);
            read_ready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                wait_valid("wrap_drain", 10, d, at1);
                chk($sformatf("wrap[%0d][%0d]", r, i), d,
                    8'h20 + 8'(r * 16 + i));
            end
        end

        // 4: pacing and a held tick
        pace_enable = 1'b1;
        read_ready  = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) push1(8'hC0 + 8'(i));
        wait_valid("pace_p1", 40, d, at1);
        chk("pace_d1", d, 8'hC0);
        wait_valid("pace_p2", 40, d, at2);
        chk("pace_d2", d, 8'hC1);
        wait_valid("pace_p3", 40, d, at3);
        chk("pace_d3", d, 8'hC2);
        chk("pace_spacing", at3 - at2, 16);
        read_ready = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (read_valid) pulses++;
        end
        chk("pace_blocked", pulses, 0);
        read_ready = 1'b1;
        step();
        chk("pace_held_issue", read_valid, 0);
        step();
        chk("pace_held_valid", read_valid, 1);
        chk("pace_held_data", read_data, 8'hC3);
        chk("pace_held_cnt", count, 0);
        pace_enable = 1'b0;

        // 5: high water
        read_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 11; i++) push1(8'(i));
        chk("hw_below", high_water, 0);
        push1(8'd11);
        chk("hw_rise", high_water, 1);
        read_ready = 1'b1;
        step();
        chk("hw_issue", high_water, 1);
        chk("hw_issue_nv", read_valid, 0);
        step();
        chk("hw_fall_v", read_valid, 1);
        chk("hw_fall", high_water, 0);

        // 6: reset during the ISSUE cycle
        read_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 17; i++) push1(8'h70 + 8'(i));
        chk("rmid_ovf_pre", overflow, 1);
        read_ready = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_count", count, 0);
        chk("rmid_ovf", overflow, 0);
        chk("rmid_full", full, 0);
        chk("rmid_valid", read_valid, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (read_valid) pulses++;
        end
        chk("rmid_nopulse", pulses, 0);
        push1(8'h99);
        wait_valid("rmid_after", 10, d, at1);
        chk("rmid_after_data", d, 8'h99);
        step();
        chk("rmid_after_cnt", count, 0);

        // randomized traffic against the queue model
        do_reset();
        for (int p = 0; p < 6; p++) begin
            pace_enable = p[0];
            wprob = (p % 3 == 0) ? 60 : ((p % 3 == 1) ? 25 : 10);
            for (int i = 0; i < 500; i++) begin
                read_ready = ($urandom_range(99) < 70);
                mstep($urandom_range(99) < wprob, 8'($urandom),
                      $urandom_range(99) < 5);
            end
        end
        pace_enable = 1'b0;
        read_ready  = 1'b1;
        for (int i = 0; i < 400 && mq.size() != 0; i++) begin
            mstep(1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 4; i++) mstep(1'b0, 8'h00, 1'b0);
        chk("rnd_final_empty", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
